// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: per-channel programmable width and period,
// continuous or one-shot, with width/period changes deferred to the period boundary.
module pulse_train_gen #(
    parameter int CH = 2,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CH-1:0] START,
    input  logic [CH-1:0] LOAD,
    input  logic [CW-1:0] W_PUL_N,
    input  logic [CW-1:0] W_PER_N,
    input  logic          MODE,
    output logic [CH-1:0] OUT,
    output logic [CH-1:0] RDY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [1:0]    st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] pul_q, pul_d;
        logic [CW-1:0] per_q, per_d;
        logic          mode_q, mode_d;
        logic [CW-1:0] sh_pul_q, sh_pul_d;
        logic [CW-1:0] sh_per_q, sh_per_d;
        logic          sh_mode_q, sh_mode_d;
        logic          pend_q, pend_d;
        logic          out_q, out_d;
        logic          rdy_q, rdy_d;
        logic          wrap;

        assign wrap = (cnt_q == per_q);

        always_comb begin
            st_d      = st_q;
            cnt_d     = cnt_q;
            pul_d     = pul_q;
            per_d     = per_q;
            mode_d    = mode_q;
            sh_pul_d  = sh_pul_q;
            sh_per_d  = sh_per_q;
            sh_mode_d = sh_mode_q;
            pend_d    = pend_q;

            case (st_q)
                ST_RUN: begin
                    if (wrap) begin
                        // A load on the wrap edge supersedes anything still pending.
                        if (LOAD[c]) begin
                            pul_d  = W_PUL_N;
                            per_d  = W_PER_N;
                            mode_d = MODE;
                        end else if (pend_q) begin
                            pul_d  = sh_pul_q;
                            per_d  = sh_per_q;
                            mode_d = sh_mode_q;
                        end
                        pend_d = 1'b0;
                        cnt_d  = '0;
                        // The mode that governed the finished period decides what follows.
                        if (mode_q) begin
                            st_d = ST_DONE;
                        end else if (!START[c]) begin
                            st_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (LOAD[c]) begin
                            sh_pul_d  = W_PUL_N;
                            sh_per_d  = W_PER_N;
                            sh_mode_d = MODE;
                            pend_d    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (LOAD[c]) begin
                        pul_d  = W_PUL_N;
                        per_d  = W_PER_N;
                        mode_d = MODE;
                    end
                    if (!START[c]) begin
                        st_d = ST_IDLE;
                    end
                end
                default: begin
                    if (LOAD[c]) begin
                        pul_d  = W_PUL_N;
                        per_d  = W_PER_N;
                        mode_d = MODE;
                    end
                    if (START[c]) begin
                        st_d  = ST_RUN;
                        cnt_d = '0;
                    end
                end
            endcase

            // Output is derived from next-state values so it lines up with the count.
            out_d = (st_d == ST_RUN) && (cnt_d < pul_d);
            rdy_d = (st_d != ST_RUN);
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                st_q      <= ST_IDLE;
                cnt_q     <= '0;
                pul_q     <= '0;
                per_q     <= '1;
                mode_q    <= 1'b0;
                sh_pul_q  <= '0;
                sh_per_q  <= '1;
                sh_mode_q <= 1'b0;
                pend_q    <= 1'b0;
                out_q     <= 1'b0;
                rdy_q     <= 1'b1;
            end else begin
                st_q      <= st_d;
                cnt_q     <= cnt_d;
                pul_q     <= pul_d;
                per_q     <= per_d;
                mode_q    <= mode_d;
                sh_pul_q  <= sh_pul_d;
                sh_per_q  <= sh_per_d;
                sh_mode_q <= sh_mode_d;
                pend_q    <= pend_d;
                out_q     <= out_d;
                rdy_q     <= rdy_d;
            end
        end

        assign OUT[c] = out_q;
        assign RDY[c] = rdy_q;
    end

endmodule
